// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory block protocol.
package mem_pkg;

    localparam int BLOCKSIZE      = 128;
    localparam int BYTE_ADDR_BITS = 4;
    localparam int TMR_W          = 4;

    typedef enum logic [2:0] {
        D_IDLE    = 3'd0,
        D_WB_REQ  = 3'd1,
        D_WB_WAIT = 3'd2,
        D_RF_REQ  = 3'd3,
        D_RF_WAIT = 3'd4,
        D_RESP    = 3'd5
    } dreq_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_REQ  = 2'd1,
        I_WAIT = 2'd2,
        I_RESP = 2'd3
    } ireq_state_t;

    // Clears the byte offset so the memory always sees a block address.
    function automatic logic [31:0] block_align(input logic [31:0] addr);
        return {addr[31:BYTE_ADDR_BITS], {BYTE_ADDR_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/imem_refill_fsm.sv
// Instruction-side refill engine: read-only requests on memory port 2.
//
// state  | meaning
// I_IDLE | waiting for an I-cache miss
// I_REQ  | Valid2 pulse on the port
// I_WAIT | waiting for Ready2, re-issues on timeout
// I_RESP | refill data captured, pulse goes out next cycle
module imem_refill_fsm
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 miss_valid,
    input  logic [31:0]          miss_addr,
    output logic                 busy,
    output logic                 refill_valid,
    output logic [BLOCKSIZE-1:0] refill_data,
    output logic                 valid,
    output logic [31:0]          raddr,
    input  logic                 ready,
    input  logic [BLOCKSIZE-1:0] rdata
);

    ireq_state_t      state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic             capture;
    logic             accept;

    // Next-state decode; Ready is only honoured while waiting.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            I_IDLE: if (miss_valid) begin
                accept  = 1'b1;
                state_d = I_REQ;
            end
            I_REQ:  state_d = I_WAIT;
            I_WAIT: begin
                if (ready) begin
                    capture = 1'b1;
                    state_d = I_RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT)) begin
                    state_d = I_REQ;
                end
            end
            I_RESP: state_d = I_IDLE;
            default: state_d = I_IDLE;
        endcase
    end

    // State register and wait timer, timer cleared whenever WAIT is (re)entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= I_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (state_q == I_WAIT && state_d == I_WAIT) ? tmr_q + TMR_W'(1) : '0;
        end
    end

    // Registered outputs; the refill pulse trails the RESP state by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid        <= 1'b0;
            busy         <= 1'b0;
            refill_valid <= 1'b0;
            refill_data  <= '0;
            raddr        <= '0;
        end else begin
            valid        <= (state_d == I_REQ);
            busy         <= (state_d != I_IDLE);
            refill_valid <= (state_q == I_RESP);
            if (capture) refill_data <= rdata;
            if (accept)  raddr       <= block_align(miss_addr);
        end
    end

endmodule

// File: rtl/mainmem_requester.sv
// Memory requester: D path (port 1, writeback + refill) lives here, I path in a sub-module.
//
// state     | meaning
// D_IDLE    | waiting for a D-cache miss
// D_WB_REQ  | write pulse for the dirty victim
// D_WB_WAIT | waiting for writeback Ready1, re-issues on timeout
// D_RF_REQ  | read pulse for the miss block
// D_RF_WAIT | waiting for refill Ready1, re-issues on timeout
// D_RESP    | refill data captured, pulse goes out next cycle
module mainmem_requester
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dMissValid_i,
    input  logic [31:0]          dMissAddr_i,
    input  logic                 dDirty_i,
    input  logic [31:0]          dVictimAddr_i,
    input  logic [BLOCKSIZE-1:0] dVictimData_i,
    output logic                 dBusy_o,
    output logic                 dRefillValid_o,
    output logic [BLOCKSIZE-1:0] dRefillData_o,
    input  logic                 iMissValid_i,
    input  logic [31:0]          iMissAddr_i,
    output logic                 iBusy_o,
    output logic                 iRefillValid_o,
    output logic [BLOCKSIZE-1:0] iRefillData_o,
    output logic                 Valid1_o,
    output logic                 Wen_o,
    output logic [31:0]          rAddr1_o,
    output logic [31:0]          wAddr_o,
    output logic [BLOCKSIZE-1:0] WriteD_o,
    input  logic                 Ready1_i,
    input  logic [BLOCKSIZE-1:0] ReadD1_i,
    output logic                 Valid2_o,
    output logic [31:0]          rAddr2_o,
    input  logic                 Ready2_i,
    input  logic [BLOCKSIZE-1:0] ReadD2_i
);

    dreq_state_t      state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic             timed_out;
    logic             capture;
    logic             accept;

    assign timed_out = (tmr_q == TMR_W'(TIMEOUT));

    // D-path next-state decode; writeback always precedes the refill read.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            D_IDLE: if (dMissValid_i) begin
                accept  = 1'b1;
                state_d = dDirty_i ? D_WB_REQ : D_RF_REQ;
            end
            D_WB_REQ:  state_d = D_WB_WAIT;
            D_WB_WAIT: begin
                if (Ready1_i)       state_d = D_RF_REQ;
                else if (timed_out) state_d = D_WB_REQ;
            end
            D_RF_REQ:  state_d = D_RF_WAIT;
            D_RF_WAIT: begin
                if (Ready1_i) begin
                    capture = 1'b1;
                    state_d = D_RESP;
                end else if (timed_out) begin
                    state_d = D_RF_REQ;
                end
            end
            D_RESP:  state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    // State register; one timer serves both WAIT states since only one is ever active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= D_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (state_q == state_d &&
                        (state_q == D_WB_WAIT || state_q == D_RF_WAIT)) ? tmr_q + TMR_W'(1) : '0;
        end
    end

    // Registered port-1 and D-cache outputs; addresses/victim data latched at acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            Valid1_o       <= 1'b0;
            Wen_o          <= 1'b0;
            dBusy_o        <= 1'b0;
            dRefillValid_o <= 1'b0;
            dRefillData_o  <= '0;
            rAddr1_o       <= '0;
            wAddr_o        <= '0;
            WriteD_o       <= '0;
        end else begin
            Valid1_o       <= (state_d == D_WB_REQ) || (state_d == D_RF_REQ);
            Wen_o          <= (state_d == D_WB_REQ);
            dBusy_o        <= (state_d != D_IDLE);
            dRefillValid_o <= (state_q == D_RESP);
            if (capture) dRefillData_o <= ReadD1_i;
            if (accept) begin
                rAddr1_o <= block_align(dMissAddr_i);
                wAddr_o  <= block_align(dVictimAddr_i);
                WriteD_o <= dVictimData_i;
            end
        end
    end

    imem_refill_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_imem (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .miss_valid   (iMissValid_i),
        .miss_addr    (iMissAddr_i),
        .busy         (iBusy_o),
        .refill_valid (iRefillValid_o),
        .refill_data  (iRefillData_o),
        .valid        (Valid2_o),
        .raddr        (rAddr2_o),
        .ready        (Ready2_i),
        .rdata        (ReadD2_i)
    );

endmodule

// File: tb/tb_mainmem_requester.sv
// Directed bench for mainmem_requester with a one-cycle-latency memory responder.
module tb_mainmem_requester;
    import mem_pkg::*;

    localparam int TO = 15;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 dMissValid_i, dDirty_i, iMissValid_i;
    logic [31:0]          dMissAddr_i, dVictimAddr_i, iMissAddr_i;
    logic [BLOCKSIZE-1:0] dVictimData_i;
    logic                 dBusy_o, dRefillValid_o, iBusy_o, iRefillValid_o;
    logic [BLOCKSIZE-1:0] dRefillData_o, iRefillData_o, WriteD_o;
    logic                 Valid1_o, Wen_o, Valid2_o;
    logic [31:0]          rAddr1_o, wAddr_o, rAddr2_o;
    logic                 Ready1_i, Ready2_i;
    logic [BLOCKSIZE-1:0] rd1, rd2;

    logic resp1 = 1'b0, resp2 = 1'b0, force1 = 1'b0, v1_prev = 1'b0, v2_prev = 1'b0;
    logic en1 = 1'b0, en2 = 1'b0;
    assign Ready1_i = resp1 | force1;
    assign Ready2_i = resp2;

    always #5 clk_i = ~clk_i;

    mainmem_requester #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dMissValid_i(dMissValid_i), .dMissAddr_i(dMissAddr_i), .dDirty_i(dDirty_i),
        .dVictimAddr_i(dVictimAddr_i), .dVictimData_i(dVictimData_i),
        .dBusy_o(dBusy_o), .dRefillValid_o(dRefillValid_o), .dRefillData_o(dRefillData_o),
        .iMissValid_i(iMissValid_i), .iMissAddr_i(iMissAddr_i),
        .iBusy_o(iBusy_o), .iRefillValid_o(iRefillValid_o), .iRefillData_o(iRefillData_o),
        .Valid1_o(Valid1_o), .Wen_o(Wen_o), .rAddr1_o(rAddr1_o), .wAddr_o(wAddr_o),
        .WriteD_o(WriteD_o), .Ready1_i(Ready1_i), .ReadD1_i(rd1),
        .Valid2_o(Valid2_o), .rAddr2_o(rAddr2_o), .Ready2_i(Ready2_i), .ReadD2_i(rd2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int                   v1_n = 0, v2_n = 0, dp_n = 0, ip_n = 0;
    int                   v1_cyc[64], v2_cyc[64];
    logic                 v1_wen[64];
    logic [31:0]          v1_addr[64], v2_addr[64];
    logic [BLOCKSIZE-1:0] v1_data[64];
    int                   d_cyc = 0, i_cyc = 0;
    logic [BLOCKSIZE-1:0] d_data = '0, i_data = '0;

    // Memory responder (Ready one cycle after Valid) and event log, all at negedge.
    always @(negedge clk_i) begin
        resp1   = v1_prev & en1;
        resp2   = v2_prev & en2;
        v1_prev = Valid1_o;
        v2_prev = Valid2_o;
        if (Valid1_o) begin
            if (v1_n < 64) begin
                v1_cyc[v1_n]  = cyc;
                v1_wen[v1_n]  = Wen_o;
                v1_addr[v1_n] = Wen_o ? wAddr_o : rAddr1_o;
                v1_data[v1_n] = WriteD_o;
            end
            v1_n++;
        end
        if (Valid2_o) begin
            if (v2_n < 64) begin
                v2_cyc[v2_n]  = cyc;
                v2_addr[v2_n] = rAddr2_o;
            end
            v2_n++;
        end
        if (dRefillValid_o) begin
            d_cyc  = cyc;
            d_data = dRefillData_o;
            dp_n++;
        end
        if (iRefillValid_o) begin
            i_cyc  = cyc;
            i_data = iRefillData_o;
            ip_n++;
        end
    end

    function automatic int count_of(input int sel);
        case (sel)
            0:       return dp_n;
            1:       return ip_n;
            2:       return v1_n;
            default: return v2_n;
        endcase
    endfunction

    task automatic wait_count(input string tag, input int sel, input int target, input int budget);
        int n = 0;
        while (count_of(sel) < target && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        if (count_of(sel) < target) check({tag, "_timeout"}, 128'(count_of(sel)), 128'(target));
    endtask

    task automatic d_miss(input logic [31:0] a, input logic dirty, input logic [31:0] va,
                          input logic [127:0] vd, output int c);
        @(negedge clk_i);
        dMissValid_i  = 1'b1;
        dMissAddr_i   = a;
        dDirty_i      = dirty;
        dVictimAddr_i = va;
        dVictimData_i = vd;
        c = cyc;
        @(negedge clk_i);
        dMissValid_i = 1'b0;
        dDirty_i     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, b1, b2, bd, bi;
        rst_ni = 1'b0;
        dMissValid_i = 1'b0; dDirty_i = 1'b0; iMissValid_i = 1'b0;
        dMissAddr_i = '0; dVictimAddr_i = '0; iMissAddr_i = '0; dVictimData_i = '0;
        rd1 = '0; rd2 = '0;
        repeat (2) @(negedge clk_i);
        check("rst_valid1", 128'(Valid1_o), 128'(0));
        check("rst_busy", 128'({dBusy_o, iBusy_o}), 128'(0));
        check("rst_addr", 128'({rAddr1_o, wAddr_o, rAddr2_o}), 128'(0));
        check("rst_data", dRefillData_o | iRefillData_o | WriteD_o, 128'(0));
        rst_ni = 1'b1;

        // 1: reset in the middle of RF_WAIT, then a stray Ready1
        d_miss(32'h0001_0040, 1'b0, 32'h0, 128'h0, c);
        check("t1_busy", 128'(dBusy_o), 128'(1));
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("t1_rst_addr", 128'(rAddr1_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        force1 = 1'b1;
        @(negedge clk_i);
        force1 = 1'b0;
        repeat (4) @(negedge clk_i);
        check("t1_no_refill", 128'(dp_n), 128'(0));
        check("t1_idle", 128'({Valid1_o, dBusy_o}), 128'(0));

        // 2: clean D miss
        en1 = 1'b1;
        rd1 = {16{8'hAA}};
        b1 = v1_n; bd = dp_n;
        d_miss(32'h0001_0024, 1'b0, 32'h0, 128'h0, c);
        wait_count("t2_refill", 0, bd + 1, 20);
        check("t2_v1_cyc", 128'(v1_cyc[b1] - c), 128'(1));
        check("t2_wen", 128'(v1_wen[b1]), 128'(0));
        check("t2_raddr", 128'(v1_addr[b1]), 128'(32'h0001_0020));
        check("t2_latency", 128'(d_cyc - c), 128'(4));
        check("t2_data", d_data, {16{8'hAA}});
        @(negedge clk_i);
        check("t2_idle", 128'({dBusy_o, v1_n - b1}), 128'({1'b0, 32'd1}));

        // 3: dirty D miss, writeback then refill
        rd1 = 128'h5555_6666_7777_8888_9999_0000_1111_2222;
        b1 = v1_n; bd = dp_n;
        d_miss(32'h0001_0208, 1'b1, 32'h0001_0100, 128'h1234, c);
        wait_count("t3_refill", 0, bd + 1, 30);
        check("t3_wr", 128'({v1_wen[b1], v1_addr[b1]}), 128'({1'b1, 32'h0001_0100}));
        check("t3_wdata", v1_data[b1], 128'h1234);
        check("t3_wr_cyc", 128'(v1_cyc[b1] - c), 128'(1));
        check("t3_rd", 128'({v1_wen[b1+1], v1_addr[b1+1]}), 128'({1'b0, 32'h0001_0200}));
        check("t3_rd_cyc", 128'(v1_cyc[b1+1] - c), 128'(3));
        check("t3_latency", 128'(d_cyc - c), 128'(6));
        check("t3_data", d_data, 128'h5555_6666_7777_8888_9999_0000_1111_2222);

        // 4: concurrent I and D misses
        en2 = 1'b1;
        rd1 = {16{8'hD0}};
        rd2 = {8{16'h1357}};
        b1 = v1_n; b2 = v2_n; bd = dp_n; bi = ip_n;
        @(negedge clk_i);
        dMissValid_i = 1'b1; dMissAddr_i = 32'h0004_0000; dDirty_i = 1'b0;
        iMissValid_i = 1'b1; iMissAddr_i = 32'hBFC0_0008;
        c = cyc;
        @(negedge clk_i);
        dMissValid_i = 1'b0; iMissValid_i = 1'b0;
        wait_count("t4_drefill", 0, bd + 1, 20);
        wait_count("t4_irefill", 1, bi + 1, 20);
        check("t4_v1_cyc", 128'(v1_cyc[b1] - c), 128'(1));
        check("t4_v2_cyc", 128'(v2_cyc[b2] - c), 128'(1));
        check("t4_raddr2", 128'(v2_addr[b2]), 128'(32'hBFC0_0000));
        check("t4_i_latency", 128'(i_cyc - c), 128'(4));
        check("t4_same_cyc", 128'(d_cyc - i_cyc), 128'(0));
        check("t4_idata", i_data, {8{16'h1357}});
        check("t4_ddata", d_data, {16{8'hD0}});

        // 5: withheld Ready2 forces a re-issue after the timeout
        en2 = 1'b0;
        rd2 = 128'hCAFE_F00D;
        b2 = v2_n; bi = ip_n;
        @(negedge clk_i);
        iMissValid_i = 1'b1; iMissAddr_i = 32'h0000_1234;
        c = cyc;
        @(negedge clk_i);
        iMissValid_i = 1'b0;
        wait_count("t5_reissue", 3, b2 + 2, 60);
        en2 = 1'b1;
        check("t5_gap", 128'(v2_cyc[b2+1] - v2_cyc[b2]), 128'(TO + 2));
        check("t5_addr", 128'(v2_addr[b2+1]), 128'(32'h0000_1230));
        wait_count("t5_refill", 1, bi + 1, 20);
        repeat (30) @(negedge clk_i);
        check("t5_one_pulse", 128'(ip_n - bi), 128'(1));
        check("t5_no_more_v2", 128'(v2_n - b2), 128'(2));
        check("t5_i_cyc", 128'(i_cyc - v2_cyc[b2+1]), 128'(3));
        check("t5_idata", i_data, 128'hCAFE_F00D);
        en2 = 1'b0;

        // 6: second miss while busy waits for IDLE
        en1 = 1'b1;
        rd1 = {4{32'h0BAD_BEEF}};
        b1 = v1_n; bd = dp_n;
        @(negedge clk_i);
        dMissValid_i = 1'b1; dMissAddr_i = 32'h0002_0010; dDirty_i = 1'b0;
        c = cyc;
        @(negedge clk_i);
        dMissAddr_i = 32'h0003_0038;
        for (int n = 0; n < 20 && v1_n < b1 + 2; n++) @(negedge clk_i);
        dMissValid_i = 1'b0;
        wait_count("t6_refill", 0, bd + 2, 30);
        check("t6_first_addr", 128'(v1_addr[b1]), 128'(32'h0002_0010));
        check("t6_second_addr", 128'(v1_addr[b1+1]), 128'(32'h0003_0030));
        check("t6_second_cyc", 128'(v1_cyc[b1+1] - c), 128'(5));
        repeat (4) @(negedge clk_i);
        check("t6_counts", 128'({v1_n - b1, dp_n - bd}), 128'({32'd2, 32'd2}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
